// File: rtl/debug_pin_pkg.sv
// Shared types for the debug pin driver.
// Channel mode encoding and config-select constants.
package debug_pin_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    TOGGLE = 2'd1,
    WALK   = 2'd2,
    HIZ    = 2'd3
  } mode_e;

  localparam logic SEL_CHAN = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

endpackage

// File: rtl/debug_tick_div.sv
// Reloadable tick divider with registered tick output.
// o_hit is the combinational tick event for the edge about to happen.
module debug_tick_div #(
  parameter int DivWidth = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [DivWidth-1:0] i_reload,
  output logic                o_hit,
  output logic                o_tick
);

  logic [DivWidth-1:0] r_reload;
  logic [DivWidth-1:0] r_cnt;
  logic                r_tick;

  // a reload on the match edge swallows that tick
  assign o_hit  = ~i_load & (r_cnt == r_reload);
  assign o_tick = r_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reload <= '0;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
    end else if (i_load) begin
      r_reload <= i_reload;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= o_hit;
      r_cnt  <= o_hit ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debug_pin_driver.sv
// Run-time configurable driver for debug and spare board pins.
// Writes are captured on accept and applied on the following edge.
module debug_pin_driver
  import debug_pin_pkg::*;
#(
  parameter int   ChanCount  = 8,
  parameter int   DivWidth   = 8,
  parameter logic ResetLevel = 1'b1,
  localparam int  ChanW      = (ChanCount > 1) ? $clog2(ChanCount) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_sel,
  input  logic [ChanW-1:0]     cfg_chan,
  input  logic [1:0]           cfg_mode,
  input  logic                 cfg_level,
  input  logic [DivWidth-1:0]  cfg_div,
  output logic                 cfg_err,
  output logic                 tick,
  output logic [ChanCount-1:0] pin_out,
  output logic [ChanCount-1:0] pin_oe
);

  logic                 r_ready;
  logic                 r_pend;
  logic                 r_p_sel;
  logic [ChanW-1:0]     r_p_chan;
  mode_e                r_p_mode;
  logic                 r_p_level;
  logic [DivWidth-1:0]  r_p_div;
  logic                 r_err;
  logic [ChanW-1:0]     r_ptr;
  logic [ChanCount-1:0] r_out;
  logic [ChanCount-1:0] r_oe;
  mode_e                r_mode [ChanCount];

  logic                 w_acc;
  logic                 w_load;
  logic                 w_chan_ok;
  logic                 w_wr_chan;
  logic                 w_wr_bad;
  logic                 w_hit;
  logic [ChanW-1:0]     w_ptr_nxt;
  logic [ChanCount-1:0] w_out_nxt;
  logic [ChanCount-1:0] w_oe_nxt;
  mode_e                w_mode_nxt [ChanCount];

  assign w_acc     = cfg_valid & r_ready;
  assign w_load    = r_pend & (r_p_sel == SEL_DIV);
  assign w_chan_ok = {1'b0, r_p_chan} < (ChanW + 1)'(ChanCount);
  assign w_wr_chan = r_pend & (r_p_sel == SEL_CHAN) & w_chan_ok;
  assign w_wr_bad  = r_pend & (r_p_sel == SEL_CHAN) & ~w_chan_ok;

  assign cfg_ready = r_ready;
  assign cfg_err   = r_err;
  assign pin_out   = r_out;
  assign pin_oe    = r_oe;

  debug_tick_div #(
    .DivWidth (DivWidth)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_reload (r_p_div),
    .o_hit    (w_hit),
    .o_tick   (tick)
  );

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_hit) begin
      w_ptr_nxt = (r_ptr == ChanW'(ChanCount - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // a write to a channel wins over that channel's tick action
  always_comb begin
    w_out_nxt = r_out;
    w_oe_nxt  = r_oe;
    for (int i = 0; i < ChanCount; i++) begin
      w_mode_nxt[i] = r_mode[i];
      if (w_wr_chan && (r_p_chan == ChanW'(i))) begin
        w_mode_nxt[i] = r_p_mode;
        w_oe_nxt[i]   = (r_p_mode != HIZ);
        unique case (r_p_mode)
          HOLD, TOGGLE: w_out_nxt[i] = r_p_level;
          WALK:         w_out_nxt[i] = (w_ptr_nxt == ChanW'(i));
          HIZ:          w_out_nxt[i] = r_out[i];
        endcase
      end else begin
        unique case (r_mode[i])
          TOGGLE:  w_out_nxt[i] = r_out[i] ^ w_hit;
          WALK:    w_out_nxt[i] = (w_ptr_nxt == ChanW'(i));
          default: w_out_nxt[i] = r_out[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready   <= 1'b1;
      r_pend    <= 1'b0;
      r_p_sel   <= SEL_CHAN;
      r_p_chan  <= '0;
      r_p_mode  <= HOLD;
      r_p_level <= 1'b0;
      r_p_div   <= '0;
      r_err     <= 1'b0;
      r_ptr     <= '0;
      r_out     <= {ChanCount{ResetLevel}};
      r_oe      <= '1;
      for (int i = 0; i < ChanCount; i++) begin
        r_mode[i] <= HOLD;
      end
    end else begin
      r_ready <= ~w_acc;
      r_pend  <= w_acc;
      if (w_acc) begin
        r_p_sel   <= cfg_sel;
        r_p_chan  <= cfg_chan;
        r_p_mode  <= mode_e'(cfg_mode);
        r_p_level <= cfg_level;
        r_p_div   <= cfg_div;
      end
      r_err  <= w_wr_bad;
      r_ptr  <= w_ptr_nxt;
      r_out  <= w_out_nxt;
      r_oe   <= w_oe_nxt;
      r_mode <= w_mode_nxt;
    end
  end

endmodule

// File: tb/tb_debug_pin_driver.sv
// Bench for debug_pin_driver: 8- and 6-channel instances on shared stimulus.
// Outputs are compared every cycle against a cycle-level behavioural model.
module tb_debug_pin_driver;

  localparam int MH = 0, MT = 1, MW = 2, MZ = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_sel = 1'b0;
  logic [2:0] cfg_chan = '0;
  logic [1:0] cfg_mode = '0;
  logic       cfg_level = 1'b0;
  logic [7:0] cfg_div = '0;

  logic       rdy8, err8, tick8;
  logic [7:0] out8, oe8;
  logic       rdy6, err6, tick6;
  logic [5:0] out6, oe6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  debug_pin_driver #(.ChanCount(8)) u_dut8 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy8),
    .cfg_sel(cfg_sel), .cfg_chan(cfg_chan), .cfg_mode(cfg_mode),
    .cfg_level(cfg_level), .cfg_div(cfg_div), .cfg_err(err8),
    .tick(tick8), .pin_out(out8), .pin_oe(oe8)
  );

  debug_pin_driver #(.ChanCount(6)) u_dut6 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy6),
    .cfg_sel(cfg_sel), .cfg_chan(cfg_chan), .cfg_mode(cfg_mode),
    .cfg_level(cfg_level), .cfg_div(cfg_div), .cfg_err(err6),
    .tick(tick6), .pin_out(out6), .pin_oe(oe6)
  );

  // reference model state (index 0: 8 channels, 1: 6 channels)
  int         m_cnt, m_reload;
  logic       m_tick, m_ready, m_pend;
  logic       p_sel, p_level;
  int         p_chan, p_mode, p_div;
  int         m_ptr [2];
  int         m_mode [2][8];
  logic [7:0] m_out [2];
  logic [7:0] m_oe [2];
  logic       m_err [2];
  int         nch [2] = '{8, 6};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic acc, ld, hit, wr;
    if (rst) begin
      m_cnt = 0; m_reload = 0; m_tick = 0; m_ready = 1; m_pend = 0;
      for (int k = 0; k < 2; k++) begin
        m_ptr[k] = 0; m_out[k] = '1; m_oe[k] = '1; m_err[k] = 0;
        for (int i = 0; i < 8; i++) m_mode[k][i] = MH;
      end
      return;
    end
    acc = cfg_valid && m_ready;
    ld  = m_pend && p_sel;
    hit = !ld && (m_cnt == m_reload);
    if (ld) begin
      m_reload = p_div;
      m_cnt = 0;
    end else if (hit) m_cnt = 0;
    else m_cnt++;
    m_tick = hit;
    for (int k = 0; k < 2; k++) begin
      if (hit) m_ptr[k] = (m_ptr[k] + 1) % nch[k];
      m_err[k] = m_pend && !p_sel && (p_chan >= nch[k]);
      for (int i = 0; i < nch[k]; i++) begin
        wr = m_pend && !p_sel && (p_chan == i);
        if (wr) begin
          m_mode[k][i] = p_mode;
          m_oe[k][i] = (p_mode != MZ);
          if (p_mode == MH || p_mode == MT) m_out[k][i] = p_level;
          else if (p_mode == MW) m_out[k][i] = (m_ptr[k] == i);
        end else if (m_mode[k][i] == MT && hit) begin
          m_out[k][i] = ~m_out[k][i];
        end else if (m_mode[k][i] == MW) begin
          m_out[k][i] = (m_ptr[k] == i);
        end
      end
    end
    m_pend = acc;
    m_ready = !acc;
    if (acc) begin
      p_sel = cfg_sel; p_chan = cfg_chan; p_mode = cfg_mode;
      p_level = cfg_level; p_div = cfg_div;
    end
  endtask

  task automatic check_all();
    chk("out8", out8, m_out[0]);
    chk("oe8", oe8, m_oe[0]);
    chk("out6", out6, m_out[1][5:0]);
    chk("oe6", oe6, m_oe[1][5:0]);
    chk("tick8", tick8, m_tick);
    chk("tick6", tick6, m_tick);
    chk("ready8", rdy8, m_ready);
    chk("ready6", rdy6, m_ready);
    chk("err8", err8, m_err[0]);
    chk("err6", err6, m_err[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wr(input logic sel, input int chan, input int mode,
                    input logic lvl, input int div);
    int n;
    n = 0;
    while (!m_ready && n < 10) begin
      cycle();
      n++;
    end
    chk("wr_ready_bound", m_ready, 1'b1);
    cfg_valid = 1; cfg_sel = sel; cfg_chan = 3'(chan);
    cfg_mode = 2'(mode); cfg_level = lvl; cfg_div = 8'(div);
    cycle();
    cfg_valid = 0;
  endtask

  initial begin
    int last, acc, n;
    logic prev;
    // reset
    rst = 1;
    repeat (3) cycle();
    rst = 0;
    chk("rst_out8", out8, 8'hFF);
    chk("rst_oe8", oe8, 8'hFF);
    chk("rst_ready", rdy8, 1'b1);
    chk("rst_tick", tick8, 1'b0);
    chk("rst_err", err8, 1'b0);
    cycle();
    // divider period and toggle
    wr(1, 0, 0, 0, 3);
    wr(0, 2, MT, 0, 0);
    cycle();
    last = -1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (tick8) begin
        if (last >= 0) chk("div_period", c - last, 4);
        last = c;
      end
    end
    // walking one
    wr(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) wr(0, i, MW, 0, 0);
    cycle();
    for (int c = 0; c < 12; c++) begin
      cycle();
      chk("onehot8", $countones(out8), 1);
      chk("onehot6", $countones(out6), 1);
    end
    // handshake with valid held
    repeat (2) cycle();
    acc = 0;
    cfg_valid = 1;
    for (int j = 0; j < 6; j++) begin
      cfg_sel = 0; cfg_chan = 3'(j); cfg_mode = 2'(MH);
      cfg_level = j[0];
      chk("hs_ready", rdy8, (j % 2 == 0) ? 1 : 0);
      if (rdy8) acc++;
      cycle();
    end
    cfg_valid = 0;
    chk("hs_accepts", acc, 3);
    cycle();
    // write colliding with a tick, then HIZ
    wr(1, 0, 0, 0, 3);
    cycle();
    n = 0;
    while (!(m_cnt == m_reload - 1 && m_ready) && n < 20) begin
      cycle();
      n++;
    end
    chk("coll_bound", n < 20, 1'b1);
    cfg_valid = 1; cfg_sel = 0; cfg_chan = 3'd1;
    cfg_mode = 2'(MT); cfg_level = 1;
    cycle();
    cfg_valid = 0;
    cycle();
    chk("coll_tick", tick8, 1'b1);
    chk("coll_out", out8[1], 1'b1);
    wr(0, 1, MZ, 0, 0);
    prev = out8[1];
    cycle();
    chk("hiz_oe", oe8[1], 1'b0);
    chk("hiz_out", out8[1], prev);
    // out-of-range channel on the 6-channel instance
    wr(0, 7, MH, 0, 0);
    cycle();
    chk("oor_err6", err6, 1'b1);
    chk("oor_err8", err8, 1'b0);
    cycle();
    chk("oor_err6_off", err6, 1'b0);
    // reset wins over a presented write
    cfg_valid = 1; cfg_sel = 0; cfg_chan = 3'd0;
    cfg_mode = 2'(MH); cfg_level = 0;
    rst = 1;
    cycle();
    rst = 0; cfg_valid = 0;
    chk("rstw_out8", out8, 8'hFF);
    chk("rstw_oe8", oe8, 8'hFF);
    chk("rstw_ready", rdy8, 1'b1);
    cycle();
    chk("rstw_drop", out8, 8'hFF);
    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      cfg_valid = $urandom_range(0, 1);
      cfg_sel = ($urandom_range(0, 4) == 0);
      cfg_chan = 3'($urandom_range(0, 7));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_level = 1'($urandom_range(0, 1));
      cfg_div = 8'($urandom_range(0, 5));
      cycle();
    end
    rst = 0; cfg_valid = 0;
    cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
